// File: rtl/p2_vector_sequencer.sv
// Steps through a fixed 4-entry operand table, holds each vector for HOLD_CYCLES, then captures results.
// Optional result sum checking is built only when P2SEQ_SUM_CHECK_EN is defined.
module p2_vector_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  output logic [7:0]  op1,
  output logic [15:0] op2a,
  output logic [15:0] op2b,
  output logic [1:0]  i0,
  output logic [1:0]  i1,
  output logic [1:0]  i2,
  output logic [1:0]  i3,
  input  logic [3:0]  sol_a,
  input  logic [16:0] sol_b,
  input  logic [1:0]  sol_c,
  input  logic [1:0]  sol_d,
  output logic        cap_valid,
  output logic [1:0]  cap_index,
  output logic [3:0]  cap_a,
  output logic [16:0] cap_b,
  output logic [1:0]  cap_c,
  output logic [1:0]  cap_d,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] index;
  logic [7:0] hold_cnt;

  // Packed as {op1, op2a, op2b, i0, i1, i2, i3}.
  function automatic logic [47:0] vec_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_entry = {8'd16,  16'd5,   16'd127, 2'd1, 2'd1, 2'd1, 2'd1};
      2'd1:    vec_entry = {8'hA7,  16'd456, 16'd123, 2'd1, 2'd3, 2'd3, 2'd3};
      2'd2:    vec_entry = {8'hA7,  16'd456, 16'd123, 2'd1, 2'd1, 2'd3, 2'd3};
      default: vec_entry = {8'hA7,  16'd456, 16'd123, 2'd1, 2'd0, 2'd1, 2'd0};
    endcase
  endfunction

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      index     <= 2'd0;
      hold_cnt  <= 8'd0;
      {op1, op2a, op2b, i0, i1, i2, i3} <= 48'd0;
      cap_valid <= 1'b0;
      cap_index <= 2'd0;
      cap_a     <= 4'd0;
      cap_b     <= 17'd0;
      cap_c     <= 2'd0;
      cap_d     <= 2'd0;
    end else begin
      cap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_DRIVE;
            index    <= 2'd0;
            hold_cnt <= 8'd0;
            {op1, op2a, op2b, i0, i1, i2, i3} <= vec_entry(2'd0);
          end
        end
        S_DRIVE: begin
          if (!pause) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt == HOLD_LAST) state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // Results are taken at the end of the single sample cycle; the strobe lands one cycle later.
          cap_a     <= sol_a;
          cap_b     <= sol_b;
          cap_c     <= sol_c;
          cap_d     <= sol_d;
          cap_index <= index;
          cap_valid <= 1'b1;
          if (index == 2'd3) begin
            state <= S_DONE;
          end else begin
            index    <= index + 2'd1;
            hold_cnt <= 8'd0;
            state    <= S_DRIVE;
            {op1, op2a, op2b, i0, i1, i2, i3} <= vec_entry(index + 2'd1);
          end
        end
        default: begin
          state <= S_IDLE;
          {op1, op2a, op2b, i0, i1, i2, i3} <= 48'd0;
        end
      endcase
    end
  end

`ifdef P2SEQ_SUM_CHECK_EN
  // Carry is kept so an overflowing sum is still compared exactly.
  function automatic logic [16:0] op_sum(input logic [15:0] a, input logic [15:0] b);
    op_sum = {1'b0, a} + {1'b0, b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 3'd0;
    end else if (state == S_IDLE && start) begin
      err_count <= 3'd0;
    end else if (state == S_SAMPLE && sol_b != op_sum(op2a, op2b) && err_count != 3'd7) begin
      err_count <= err_count + 3'd1;
    end
  end
`else
  assign err_count = 3'd0;
`endif

endmodule

// File: tb/tb_p2_vector_sequencer.sv
// Directed bench for p2_vector_sequencer: full runs, pause, ignored restarts, mid-run reset, sum errors.
module tb_p2_vector_sequencer;

`ifdef P2SEQ_SUM_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  op1;
  logic [15:0] op2a, op2b;
  logic [1:0]  i0, i1, i2, i3;
  logic [3:0]  sol_a;
  logic [16:0] sol_b;
  logic [1:0]  sol_c, sol_d;
  logic        cap_valid;
  logic [1:0]  cap_index;
  logic [3:0]  cap_a;
  logic [16:0] cap_b;
  logic [1:0]  cap_c, cap_d;
  logic        busy, done;
  logic [2:0]  err_count;

  logic [3:0]  force_mask = 4'b0000;
  logic [1:0]  vid;

  int passed = 0;
  int total  = 0;

  // run configuration and results
  int pause_at, pause_len, restart_at, restart_at2, abort_at;
  int busy_n, done_n, ncap, chg_n, v2_n;
  logic [2:0]  err_k1, err_done, err_pre_abort;
  logic [1:0]  r_idx [4];
  logic [3:0]  r_a   [4];
  logic [16:0] r_b   [4];
  logic [1:0]  r_c   [4];
  logic [1:0]  r_d   [4];

  // hand-computed results of the combinational model below for v0..v3
  logic [3:0]  ea [4] = '{4'd1, 4'd13, 4'd13, 4'd13};
  logic [16:0] eb [4] = '{17'd132, 17'd579, 17'd579, 17'd579};
  logic [1:0]  ec [4] = '{2'd0, 2'd2, 2'd0, 2'd1};
  logic [1:0]  ed [4] = '{2'd0, 2'd0, 2'd0, 2'd1};

  p2_vector_sequencer #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .op1(op1), .op2a(op2a), .op2b(op2b),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c), .sol_d(sol_d),
    .cap_valid(cap_valid), .cap_index(cap_index),
    .cap_a(cap_a), .cap_b(cap_b), .cap_c(cap_c), .cap_d(cap_d),
    .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational problem stage; sol_b can be forced to 0 per vector.
  always_comb begin
    vid = 2'd0;
    case ({i1, i2, i3})
      6'b111111: vid = 2'd1;
      6'b011111: vid = 2'd2;
      6'b000100: vid = 2'd3;
      default:   vid = 2'd0;
    endcase
    sol_a = op1[3:0] ^ op1[7:4];
    sol_b = force_mask[vid] ? 17'd0 : ({1'b0, op2a} + {1'b0, op2b});
    sol_c = i0 ^ i1;
    sol_d = i2 ^ i3;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ops"}, {16'd0, op1, op2a, op2b, i0, i1, i2, i3}, 64'd0);
    check({tag, "_caps"}, {28'd0, cap_valid, cap_index, cap_a, cap_b, cap_c, cap_d,
                           busy, done, err_count}, 64'd0);
  endtask

  // Pulses start at cycle 0 and watches the run until busy falls after done, or the bound expires.
  task automatic run_seq(input string tag);
    logic [47:0] prev_ops;
    logic        prev_busy;
    bit          finished;
    busy_n = 0; done_n = 0; ncap = 0; chg_n = 0; v2_n = 0;
    err_k1 = 3'd7; err_done = 3'd7; err_pre_abort = 3'd7;
    prev_ops = '0; prev_busy = 1'b0; finished = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin done_n++; err_done = err_count; end
      if (cap_valid) begin
        if (ncap < 4) begin
          r_idx[ncap] = cap_index; r_a[ncap] = cap_a; r_b[ncap] = cap_b;
          r_c[ncap] = cap_c; r_d[ncap] = cap_d;
        end
        ncap++;
      end
      if (k == 1) err_k1 = err_count;
      if (busy && prev_busy && {op1, op2a, op2b, i0, i1, i2, i3} != prev_ops) chg_n++;
      if (busy && {i1, i2, i3} == 6'b011111) v2_n++;
      prev_ops  = {op1, op2a, op2b, i0, i1, i2, i3};
      prev_busy = busy;
      if (k == abort_at) begin
        err_pre_abort = err_count;
        rst_n = 1'b0;
        #1;
        check_outputs_zero({tag, "_async_rst"});
        finished = 1;
        break;
      end
      if (k > 1 && done_n > 0 && !busy) begin
        finished = 1;
        break;
      end
      start = (k == 0) || (k == restart_at) || (k == restart_at2);
      pause = (k >= pause_at) && (k < pause_at + pause_len);
    end
    start = 1'b0;
    pause = 1'b0;
    check({tag, "_terminated"}, 64'(finished), 64'd1);
  endtask

  task automatic check_caps(input string tag, input logic [3:0] forced);
    check({tag, "_ncap"}, 64'(ncap), 64'd4);
    for (int v = 0; v < 4; v++) begin
      check($sformatf("%s_idx%0d", tag, v), 64'(r_idx[v]), 64'(v));
      check($sformatf("%s_a%0d", tag, v), 64'(r_a[v]), 64'(ea[v]));
      check($sformatf("%s_b%0d", tag, v), 64'(r_b[v]), forced[v] ? 64'd0 : 64'(eb[v]));
      check($sformatf("%s_cd%0d", tag, v), {60'd0, r_c[v], r_d[v]}, {60'd0, ec[v], ed[v]});
    end
  endtask

  task automatic defaults();
    pause_at = -1; pause_len = 0; restart_at = -1; restart_at2 = -1; abort_at = -1;
  endtask

  initial begin
    defaults();
    // reset state and no self-start
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", 64'(busy), 64'd0);

    // baseline run
    force_mask = 4'b0000;
    run_seq("base");
    check("base_busy_cycles", 64'(busy_n), 64'd21);
    check("base_done_count", 64'(done_n), 64'd1);
    check("base_err", 64'(err_done), 64'd0);
    check("base_op_changes", 64'(chg_n), 64'd3);
    check("base_v2_cycles", 64'(v2_n), 64'd5);
    check_caps("base", 4'b0000);
    check("base_ops_cleared", {16'd0, op1, op2a, op2b, i0, i1, i2, i3}, 64'd0);
    check("base_cap_hold_b", 64'(cap_b), 64'd579);

    // sum mismatch on v1 only
    force_mask = 4'b0010;
    run_seq("v1err");
    check("v1err_err_at_done", 64'(err_done), 64'(CHK));
    check("v1err_busy_cycles", 64'(busy_n), 64'd21);
    check_caps("v1err", 4'b0010);
    force_mask = 4'b0000;

    // pause for 3 cycles during v2 DRIVE
    pause_at = 11; pause_len = 3;
    run_seq("pause");
    check("pause_busy_cycles", 64'(busy_n), 64'd24);
    check("pause_v2_cycles", 64'(v2_n), 64'd8);
    check("pause_op_changes", 64'(chg_n), 64'd3);
    check_caps("pause", 4'b0000);
    defaults();

    // start re-pulsed during v1 and during the DONE cycle
    restart_at = 7; restart_at2 = 21;
    run_seq("restart");
    check("restart_busy_cycles", 64'(busy_n), 64'd21);
    check("restart_done_count", 64'(done_n), 64'd1);
    check_caps("restart", 4'b0000);
    @(negedge clk);
    check("restart_done_start_ignored", 64'(busy), 64'd0);
    defaults();

    // asynchronous reset during v2, after a v1 error
    force_mask = 4'b0010;
    abort_at = 12;
    run_seq("abort");
    check("abort_err_before_rst", 64'(err_pre_abort), 64'(CHK));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_needs_start", 64'(busy), 64'd0);
    defaults();
    force_mask = 4'b0000;
    run_seq("after_abort");
    check("after_abort_err_k1", 64'(err_k1), 64'd0);
    check("after_abort_busy_cycles", 64'(busy_n), 64'd21);
    check_caps("after_abort", 4'b0000);

    // every vector wrong over two runs; second start clears the count
    force_mask = 4'b1111;
    run_seq("allerr1");
    check("allerr1_err", 64'(err_done), 64'(4 * CHK));
    check_caps("allerr1", 4'b1111);
    run_seq("allerr2");
    check("allerr2_err_cleared", 64'(err_k1), 64'd0);
    check("allerr2_err", 64'(err_done), 64'(4 * CHK));
    check("allerr2_done_count", 64'(done_n), 64'd1);
    force_mask = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
